mem_access_ctrl: RTL and testbench

Byte-serializing access controller and two-port arbiter in front of the byte-wide data RAM. Shares the one memory port between an instruction-fetch requester (read-only, word) and a data requester (LB/LBU/LH/LHU/LW/SH/SB/SW). Each access is issued as 1, 2 or 4 little-endian single-byte cycles. Read bytes are reassembled, then sign- or zero-extended before being returned with a one-cycle acknowledge.

---
 rtl/mem_access_ctrl_if.sv | 37 +++
 rtl/mem_access_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Requester, acknowledge and byte-RAM signals shared by mem_access_ctrl and its environment.
// The slave modport is the controller's view; master is the surrounding system's view.
interface mem_access_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [31:0]       i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [1:0]        d_size;
  logic              d_unsigned;
  logic [31:0]       d_wdata;
  logic              d_ack;
  logic [31:0]       d_rdata;
  logic              d_err;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_size, d_unsigned, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, d_err, mem_addr, mem_we, mem_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_size, d_unsigned, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, d_err, mem_addr, mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Round-robin arbiter between fetch and data ports that serializes each access into
// little-endian single-byte RAM cycles and returns extended load data with a one-cycle ack.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_access_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;            // 1 = data port
  logic              last_grant_q, last_grant_d;  // 1 = data port
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              unsigned_q, unsigned_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       asm_q, asm_d;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              i_ack_q, i_ack_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic              d_ack_q, d_ack_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              d_err_q, d_err_d;
  logic              busy_q, busy_d;

  logic              grant_i, grant_d;
  logic [1:0]        last_c;
  logic              ext;
  logic [31:0]       result;

  // Index of the final byte for the latched access size
  always_comb begin
    case (size_q)
      2'b00:   last_c = 2'd0;
      2'b01:   last_c = 2'd1;
      default: last_c = 2'd3;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    we_d         = we_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    asm_d        = asm_q;
    mem_addr_d   = '0;
    mem_we_d     = 1'b0;
    mem_wdata_d  = 8'h00;
    i_ack_d      = 1'b0;
    i_rdata_d    = 32'h0;
    d_ack_d      = 1'b0;
    d_rdata_d    = 32'h0;
    d_err_d      = 1'b0;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    ext          = 1'b0;
    result       = 32'h0;

    case (state_q)
      IDLE: begin
        // On a tie the port not granted last time wins
        grant_d = bus.d_req && (!bus.i_req || !last_grant_q);
        grant_i = bus.i_req && !grant_d;
        if (grant_d || grant_i) begin
          owner_d    = grant_d;
          addr_d     = grant_d ? bus.d_addr : bus.i_addr;
          we_d       = grant_d && bus.d_we;
          size_d     = grant_d ? bus.d_size : 2'b10;
          unsigned_d = bus.d_unsigned;
          wdata_d    = bus.d_wdata;
          err_d      = grant_d && ((bus.d_size == 2'b01 && bus.d_addr[0]) ||
                                   (bus.d_size[1] && bus.d_addr[1:0] != 2'b00));
          cnt_d      = 2'd0;
          asm_d      = 32'h0;
          state_d    = XFER;
          mem_addr_d = addr_d;
          mem_we_d   = we_d;
          mem_wdata_d = we_d ? bus.d_wdata[7:0] : 8'h00;
        end
      end

      XFER: begin
        if (!we_q) asm_d[{cnt_q, 3'b000} +: 8] = bus.mem_rdata;
        if (cnt_q == last_c) begin
          state_d = DONE;
          case (size_q)
            2'b00: begin
              ext    = !unsigned_q && asm_d[7];
              result = {{24{ext}}, asm_d[7:0]};
            end
            2'b01: begin
              ext    = !unsigned_q && asm_d[15];
              result = {{16{ext}}, asm_d[15:0]};
            end
            default: result = asm_d;
          endcase
          if (owner_q) begin
            d_ack_d   = 1'b1;
            d_err_d   = err_q;
            d_rdata_d = we_q ? 32'h0 : result;
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = asm_d;
          end
        end else begin
          cnt_d       = cnt_q + 2'd1;
          mem_addr_d  = addr_q + ADDR_W'(cnt_d);
          mem_we_d    = we_q;
          mem_wdata_d = we_q ? wdata_q[{cnt_d, 3'b000} +: 8] : 8'h00;
        end
      end

      DONE: begin
        state_d      = IDLE;
        last_grant_d = owner_q;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      wdata_q      <= 32'h0;
      err_q        <= 1'b0;
      cnt_q        <= 2'd0;
      asm_q        <= 32'h0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= 8'h00;
      i_ack_q      <= 1'b0;
      i_rdata_q    <= 32'h0;
      d_ack_q      <= 1'b0;
      d_rdata_q    <= 32'h0;
      d_err_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      asm_q        <= asm_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      i_ack_q      <= i_ack_d;
      i_rdata_q    <= i_rdata_d;
      d_ack_q      <= d_ack_d;
      d_rdata_q    <= d_rdata_d;
      d_err_q      <= d_err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.i_ack     = i_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_err     = d_err_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a byte-array reference model predicts each ack,
// and a negedge monitor checks port, data, error flag, latency and the RAM byte trace.
module tb_mem_access_ctrl;
  localparam int unsigned ADDR_W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Byte RAM emulation, aliased on the low 8 address bits, with a preload port
  logic [7:0] ram [256];
  logic [7:0] model_mem [256];
  logic       init_we = 1'b0;
  logic [7:0] init_a = 8'h00;
  logic [7:0] init_d = 8'h00;

  always @(posedge clk) begin
    if (init_we) ram[init_a] <= init_d;
    else if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = ram[bus.mem_addr[7:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit               is_data;
    bit               st;
    logic [31:0]      rdata;
    bit               err;
    int               issue;
    int               lat;
    int               n;
    logic [3:0][40:0] trace;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [40:0] mon_mask;
  logic [40:0] hist [4];
  int          n_chk = 0;
  int          n_pass = 0;
  int          acks_seen = 0;
  bit          model_last = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compare every ack against the oldest prediction
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.i_ack || bus.d_ack) begin
        acks_seen++;
        chk("single_ack", 64'(bus.i_ack & bus.d_ack), 64'd0);
        if (sb.size() == 0) begin
          chk("unexpected_ack", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("ack_port", 64'(bus.d_ack), 64'(mon_e.is_data));
          chk("rdata", 64'(mon_e.is_data ? bus.d_rdata : bus.i_rdata), 64'(mon_e.rdata));
          chk("d_err", 64'(bus.d_err), 64'(mon_e.err));
          chk("latency", 64'(cyc - mon_e.issue), 64'(mon_e.lat));
          mon_mask = mon_e.st ? '1 : {32'hFFFF_FFFF, 1'b1, 8'h00};
          for (int i = 0; i < mon_e.n; i++)
            chk("mem_trace", 64'(hist[mon_e.n - 1 - i] & mon_mask), 64'(mon_e.trace[i] & mon_mask));
        end
      end else if (!bus.busy) begin
        chk("idle_mem_we", 64'(bus.mem_we), 64'd0);
      end
    end
    hist[3] <= hist[2];
    hist[2] <= hist[1];
    hist[1] <= hist[0];
    hist[0] <= {bus.mem_addr, bus.mem_we, bus.mem_wdata};
  end

  // Reference: one access as byte reads/writes of model_mem, then integer-valued extension
  task automatic model_one(input bit is_d, input logic [31:0] addr, input bit we,
                           input logic [1:0] sz, input bit uns, input logic [31:0] wd,
                           input int issue, input int lat_base, output int n_out);
    exp_t        e;
    int          n;
    int          val;
    logic [31:0] a;
    logic [7:0]  wb;
    logic [7:0]  b [4];
    n = !is_d ? 4 : (sz == 2'b00 ? 1 : (sz == 2'b01 ? 2 : 4));
    e.is_data = is_d;
    e.st      = is_d && we;
    e.trace   = '0;
    for (int i = 0; i < 4; i++) b[i] = 8'h00;
    for (int i = 0; i < n; i++) begin
      a  = addr + 32'(i);
      wb = wd[8*i +: 8];
      e.trace[i] = {a, e.st, e.st ? wb : 8'h00};
      if (e.st) model_mem[a[7:0]] = wb;
      else b[i] = model_mem[a[7:0]];
    end
    if (e.st) e.rdata = 32'h0;
    else if (n == 1) begin
      val = int'(b[0]);
      if (!uns && val >= 128) val -= 256;
      e.rdata = 32'(val);
    end else if (n == 2) begin
      val = int'(b[1]) * 256 + int'(b[0]);
      if (!uns && val >= 32768) val -= 65536;
      e.rdata = 32'(val);
    end else e.rdata = {b[3], b[2], b[1], b[0]};
    e.err   = is_d && ((n == 2 && addr % 2 != 0) || (n == 4 && addr % 4 != 0));
    e.issue = issue;
    e.lat   = lat_base + n + 1;
    e.n     = n;
    sb.push_back(e);
    n_out = n;
  endtask

  task automatic do_txn(input bit use_i, input bit use_d, input logic [31:0] ia,
                        input bit we, input logic [31:0] da, input logic [1:0] sz,
                        input bit uns, input logic [31:0] wd);
    int issue, target, n1, n2;
    bit d_first;
    @(negedge clk);
    bus.i_req = use_i;  bus.i_addr = ia;
    bus.d_req = use_d;  bus.d_we = we;  bus.d_addr = da;
    bus.d_size = sz;    bus.d_unsigned = uns;  bus.d_wdata = wd;
    issue  = cyc;
    target = acks_seen + int'(use_i) + int'(use_d);
    d_first = use_d && (!use_i || !model_last);
    if (d_first) begin
      model_one(1'b1, da, we, sz, uns, wd, issue, 0, n1);
      model_last = 1'b1;
      if (use_i) begin
        model_one(1'b0, ia, 1'b0, 2'b10, 1'b0, 32'h0, issue, n1 + 2, n2);
        model_last = 1'b0;
      end
    end else begin
      model_one(1'b0, ia, 1'b0, 2'b10, 1'b0, 32'h0, issue, 0, n1);
      model_last = 1'b0;
      if (use_d) begin
        model_one(1'b1, da, we, sz, uns, wd, issue, n1 + 2, n2);
        model_last = 1'b1;
      end
    end
    for (int k = 0; k < 40 && acks_seen < target; k++) begin
      @(negedge clk);
      #1;
      if (bus.i_ack) bus.i_req = 1'b0;
      if (bus.d_ack) bus.d_req = 1'b0;
    end
    if (acks_seen < target) begin
      chk("ack_timeout", 64'(acks_seen), 64'(target));
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      sb.delete();
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0:       return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      1, 2:    return $urandom & 32'hFFFF_FFFC;
      default: return $urandom;
    endcase
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin : main
    int          r, acks_before;
    bit          ui, ud, we, uns;
    logic [31:0] ia, da, wd;
    logic [1:0]  sz;
    logic [7:0]  old22, old23;

    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0;
    bus.d_size = 2'b00; bus.d_unsigned = 1'b0; bus.d_wdata = 32'h0;

    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      init_we = 1'b1;
      init_a  = 8'(i);
      init_d  = 8'($urandom);
      model_mem[i] = init_d;
    end
    @(negedge clk);
    init_we = 1'b0;

    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_i_ack", 64'(bus.i_ack), 64'd0);
    chk("rst_d_ack", 64'(bus.d_ack), 64'd0);
    chk("rst_i_rdata", 64'(bus.i_rdata), 64'd0);
    chk("rst_d_rdata", 64'(bus.d_rdata), 64'd0);
    chk("rst_d_err", 64'(bus.d_err), 64'd0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    reset = 1'b0;

    do_txn(1'b1, 1'b1, 32'h40, 1'b0, 32'h44, 2'b10, 1'b0, 32'h0);
    do_txn(1'b0, 1'b1, 32'h0, 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF);
    do_txn(1'b0, 1'b1, 32'h0, 1'b0, 32'h13, 2'b00, 1'b0, 32'h0);
    do_txn(1'b0, 1'b1, 32'h0, 1'b0, 32'h13, 2'b00, 1'b1, 32'h0);
    do_txn(1'b0, 1'b1, 32'h0, 1'b0, 32'h12, 2'b01, 1'b0, 32'h0);
    do_txn(1'b0, 1'b1, 32'h0, 1'b0, 32'h12, 2'b01, 1'b1, 32'h0);
    do_txn(1'b1, 1'b0, 32'h10, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    do_txn(1'b1, 1'b1, 32'h10, 1'b0, 32'h12, 2'b01, 1'b1, 32'h0);
    do_txn(1'b0, 1'b1, 32'h0, 1'b0, 32'h11, 2'b10, 1'b0, 32'h0);
    do_txn(1'b0, 1'b1, 32'h0, 1'b1, 32'h12, 2'b01, 1'b0, 32'hCAFE_1234);
    do_txn(1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);

    // Reset in the third XFER cycle of a word store
    old22 = model_mem[8'h22];
    old23 = model_mem[8'h23];
    acks_before = acks_seen;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h20;
    bus.d_size = 2'b10; bus.d_unsigned = 1'b0; bus.d_wdata = 32'h1122_3344;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("midrst_d_ack", 64'(bus.d_ack), 64'd0);
    bus.d_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_last = 1'b1;
    model_mem[8'h20] = 8'h44;
    model_mem[8'h21] = 8'h33;
    chk("midrst_byte0", 64'(ram[8'h20]), 64'h44);
    chk("midrst_byte1", 64'(ram[8'h21]), 64'h33);
    chk("midrst_byte2", 64'(ram[8'h22]), 64'(old22));
    chk("midrst_byte3", 64'(ram[8'h23]), 64'(old23));
    chk("midrst_no_ack", 64'(acks_seen), 64'(acks_before));
    do_txn(1'b0, 1'b1, 32'h0, 1'b1, 32'h20, 2'b10, 1'b0, 32'h1122_3344);
    do_txn(1'b0, 1'b1, 32'h0, 1'b0, 32'h20, 2'b10, 1'b0, 32'h0);

    for (int t = 0; t < 150; t++) begin
      r   = $urandom_range(0, 9);
      ui  = (r < 4);
      ud  = (r >= 2);
      ia  = rand_addr();
      da  = rand_addr();
      we  = ($urandom_range(0, 2) == 0);
      sz  = 2'($urandom_range(0, 3));
      uns = 1'($urandom);
      wd  = $urandom;
      do_txn(ui, ud, ia, we, da, sz, uns, wd);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
